dec: RTL and testbench
======================

// Module: dec
// PURPOSE
//  Decode stage of the 5-stage RV32I pipeline; consumes the fetch IF/ID outputs (inst, pc, nxt_pc, vld).
//  Decodes fields/immediates, reads the register file and detects load-use hazards (drives fetch i_hold).
//  Tracks ebreak/illegal halt; registers everything into the ID/EX register feeding execute.
// PARAMETERS
//  NOP_INST   32'h0000_0033  instruction word reported for bubbles (add x0,x0,x0)
//  WB_BYPASS  1              1: same-cycle WB write to rs1/rs2 forwarded into read data
// PORTS
//  i_clk          in   1   global clock
//  i_rst          in   1   synchronous active-high reset
//  i_inst         in   32  instruction from fetch IF/ID
//  i_pc           in   32  pc of i_inst
//  i_nxt_pc       in   32  pc+4 of i_inst
//  i_vld          in   1   i_inst valid
//  i_flush        in   1   branch/jump taken in EX: kill instruction entering ID/EX
//  o_rs1_raddr    out  5   regfile read port 1 addr (i_inst[19:15])
//  o_rs2_raddr    out  5   regfile read port 2 addr (i_inst[24:20])
//  i_rs1_rdata    in   32  regfile read data 1 (combinational)
//  i_rs2_rdata    in   32  regfile read data 2
//  i_ex_rd        in   5   rd of instruction currently in EX
//  i_ex_mem_read  in   1   instruction in EX is a load
//  i_wb_rd        in   5   WB write address
//  i_wb_wen       in   1   WB write enable
//  i_wb_data      in   32  WB write data
//  o_hold         out  1   stall fetch (to fet i_hold), combinational
//  o_halt         out  1   sticky halt (to fet i_halt), registered
//  o_pc, o_nxt_pc out  32  ID/EX pc, pc+4
//  o_rs1_rdata    out  32  ID/EX operand 1
//  o_rs2_rdata    out  32  ID/EX operand 2
//  o_imm          out  32  ID/EX sign-extended immediate
//  o_rd           out  5   ID/EX destination register
//  o_opsel        out  3   ID/EX funct3 (ALU / branch / mem size)
//  o_sub_sra      out  1   ID/EX funct7[5] for R-type and SRAI
//  o_alu_src      out  1   ID/EX 1: operand 2 = imm
//  o_branch, o_jal, o_jalr, o_mem_read, o_mem_write, o_reg_wen, o_lui, o_auipc  out 1 each  ID/EX ctrl
//  o_inst         out  32  ID/EX instruction word (NOP_INST for bubbles)
//  o_vld          out  1   ID/EX valid
// BEHAVIOUR
//  Reset: all ID/EX ctrl=0, o_vld=0, o_inst=NOP_INST, data/pc outputs=0, o_halt=0, FSM=RUN.
//  Latency 1 cycle: ID/EX updates every posedge from the current IF/ID contents.
//  Imm: I {20{i[31]},i[31:20]}; S {i[31:25],i[11:7]}; B {i[31],i[7],i[30:25],i[11:8],0}; U {i[31:12],12'b0};
//   J {i[31],i[19:12],i[20],i[30:21],0}; all sign-extended to 32; R-type imm=0.
//  rs-use: rs1 used by R,I,S,B,JALR; rs2 used by R,S,B. x0 reads always 0.
//  Bypass (WB_BYPASS=1): i_wb_wen & i_wb_rd!=0 & i_wb_rd==rsN -> operand N = i_wb_data.
//  Load-use: o_hold = i_vld & i_ex_mem_read & i_ex_rd!=0 & (used rs1==i_ex_rd | used rs2==i_ex_rd) & state==RUN & !i_flush.
//   On hold: ID/EX loads bubble; IF/ID keeps instruction (fet holds); single stall cycle, re-evaluated next cycle.
//  Bubble = o_vld=0, all ctrl 0, o_rd=0, o_inst=NOP_INST.
//  Priority per cycle: i_rst > i_flush > HALT state > o_hold > normal decode.
//  FSM RUN: valid ebreak (32'h0010_0073) or illegal opcode/funct -> load as valid, ctrl 0, go HALT, o_halt=1 next cycle.
//   Same cycle as i_flush: instruction killed, stay RUN. ecall decodes as no-op.
//  FSM HALT: ID/EX bubbles every cycle, o_hold=0, o_halt held 1 until i_rst.
//  Reset mid-stall or mid-halt: next cycle as reset values, FSM RUN.
//  i_vld=0 in RUN: bubble, no hazard, no halt.
// STRUCTURE
//  Package rv_pkg: opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM),
//   EBREAK word, NOP_INST value, FSM state encoding (RUN=1'b0, HALT=1'b1).
//  One sub-module: imm_gen (comb, inst -> 32-bit imm + format-valid); decode, hazard, FSM, ID/EX reg in dec.
// TESTING
//  addi x1,x0,-5 (32'hFFB0_0093) vld -> next cycle o_imm=32'hFFFF_FFFB, o_rd=1, o_alu_src=1, o_reg_wen=1.
//  beq x1,x2,-8 with rs1=rs2=7 -> o_imm=32'hFFFF_FFF8, o_branch=1, o_opsel=0, operands 7,7.
//  EX lw rd=3; ID add x4,x3,x5 -> o_hold=1 one cycle, ID/EX bubble; next cycle add issues, o_hold=0.
//  EX lw rd=0; ID add x4,x0,x0 -> o_hold=0 (x0 exempt).
//  WB x6<=32'hDEAD_BEEF same cycle as ID reads x6 (regfile stale 0) -> o_rs1_rdata=32'hDEAD_BEEF.
//  ebreak vld -> o_halt=1 next cycle, later vld instrs bubble; ebreak with i_flush -> o_halt stays 0; i_rst clears halt.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I decode constants: opcodes, special instruction words,
// decode-stage FSM states and the ID/EX control bundle.
package rv_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  localparam logic [31:0] EBREAK       = 32'h0010_0073;
  localparam logic [31:0] ECALL        = 32'h0000_0073;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0033;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

  typedef struct packed {
    logic       branch;
    logic       jal;
    logic       jalr;
    logic       mem_read;
    logic       mem_write;
    logic       reg_wen;
    logic       lui;
    logic       auipc;
    logic       alu_src;
    logic       sub_sra;
    logic [2:0] opsel;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = ctrl_t'(13'h0000);

  // Formats that actually read rs1 (R, I, S, B, JALR)
  function automatic logic uses_rs1(input logic [6:0] op);
    logic u;
    case (op)
      OP, OP_IMM, LOAD, STORE, BRANCH, JALR: u = 1'b1;
      default:                               u = 1'b0;
    endcase
    return u;
  endfunction

  // Formats that actually read rs2 (R, S, B)
  function automatic logic uses_rs2(input logic [6:0] op);
    logic u;
    case (op)
      OP, STORE, BRANCH: u = 1'b1;
      default:           u = 1'b0;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: selects the instruction format from the opcode and
// returns the sign-extended immediate plus a flag for a recognised format.
module imm_gen
  import rv_pkg::*;
(
  input  logic [31:0] inst,
  output logic [31:0] imm,
  output logic        fmt_vld
);

  // Format select and immediate assembly
  always_comb begin
    imm     = 32'h0000_0000;
    fmt_vld = 1'b1;
    case (inst[6:0])
      OP:                          imm = 32'h0000_0000;
      OP_IMM, LOAD, JALR, SYSTEM:  imm = {{20{inst[31]}}, inst[31:20]};
      STORE:                       imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      BRANCH:                      imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      LUI, AUIPC:                  imm = {inst[31:12], 12'h000};
      JAL:                         imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: begin
        imm     = 32'h0000_0000;
        fmt_vld = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/dec.sv
// RV32I decode stage: field decode, register read with WB bypass, load-use
// stall, ebreak/illegal halt FSM and the ID/EX pipeline register.
module dec
  import rv_pkg::*;
#(
  parameter logic [31:0] NOP_INST  = NOP_INST_DEF,
  parameter int          WB_BYPASS = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_nxt_pc,
  input  logic        i_vld,
  input  logic        i_flush,
  output logic [4:0]  o_rs1_raddr,
  output logic [4:0]  o_rs2_raddr,
  input  logic [31:0] i_rs1_rdata,
  input  logic [31:0] i_rs2_rdata,
  input  logic [4:0]  i_ex_rd,
  input  logic        i_ex_mem_read,
  input  logic [4:0]  i_wb_rd,
  input  logic        i_wb_wen,
  input  logic [31:0] i_wb_data,
  output logic        o_hold,
  output logic        o_halt,
  output logic [31:0] o_pc,
  output logic [31:0] o_nxt_pc,
  output logic [31:0] o_rs1_rdata,
  output logic [31:0] o_rs2_rdata,
  output logic [31:0] o_imm,
  output logic [4:0]  o_rd,
  output logic [2:0]  o_opsel,
  output logic        o_sub_sra,
  output logic        o_alu_src,
  output logic        o_branch,
  output logic        o_jal,
  output logic        o_jalr,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic        o_reg_wen,
  output logic        o_lui,
  output logic        o_auipc,
  output logic [31:0] o_inst,
  output logic        o_vld
);

  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic [6:0]  funct7_s;
  logic [4:0]  rs1_s, rs2_s, rd_s;
  logic [31:0] imm_s;
  logic        fmt_vld_s;
  logic        legal_s, halt_req_s, hold_s;
  logic        issue_s, halt_take_s;
  logic [31:0] rs1_val_s, rs2_val_s;
  ctrl_t       ctrl_s;
  state_e      state_r, state_nxt_s;

  logic        halt_r, vld_r;
  ctrl_t       ctrl_r;
  logic [4:0]  rd_r;
  logic [31:0] inst_r, pc_r, nxt_pc_r, rs1_r, rs2_r, imm_r;

  assign opcode_s    = i_inst[6:0];
  assign funct3_s    = i_inst[14:12];
  assign funct7_s    = i_inst[31:25];
  assign rs1_s       = i_inst[19:15];
  assign rs2_s       = i_inst[24:20];
  assign rd_s        = i_inst[11:7];
  assign o_rs1_raddr = rs1_s;
  assign o_rs2_raddr = rs2_s;

  imm_gen u_imm_gen (
    .inst    (i_inst),
    .imm     (imm_s),
    .fmt_vld (fmt_vld_s)
  );

  // Operand read: x0 forced to zero, same-cycle WB write wins over the stale regfile
  always_comb begin
    if (rs1_s == 5'd0) begin
      rs1_val_s = 32'h0000_0000;
    end else if ((WB_BYPASS != 0) && i_wb_wen && (i_wb_rd == rs1_s)) begin
      rs1_val_s = i_wb_data;
    end else begin
      rs1_val_s = i_rs1_rdata;
    end
    if (rs2_s == 5'd0) begin
      rs2_val_s = 32'h0000_0000;
    end else if ((WB_BYPASS != 0) && i_wb_wen && (i_wb_rd == rs2_s)) begin
      rs2_val_s = i_wb_data;
    end else begin
      rs2_val_s = i_rs2_rdata;
    end
  end

  // Control decode and legality check per opcode
  always_comb begin
    ctrl_s  = CTRL_NONE;
    legal_s = 1'b1;
    case (opcode_s)
      OP: begin
        ctrl_s.reg_wen = 1'b1;
        ctrl_s.opsel   = funct3_s;
        ctrl_s.sub_sra = funct7_s[5];
        legal_s = (funct7_s == 7'h00) ||
                  ((funct7_s == 7'h20) && ((funct3_s == 3'd0) || (funct3_s == 3'd5)));
      end
      OP_IMM: begin
        ctrl_s.reg_wen = 1'b1;
        ctrl_s.alu_src = 1'b1;
        ctrl_s.opsel   = funct3_s;
        if (funct3_s == 3'd1) begin
          legal_s = (funct7_s == 7'h00);
        end else if (funct3_s == 3'd5) begin
          legal_s        = (funct7_s == 7'h00) || (funct7_s == 7'h20);
          ctrl_s.sub_sra = funct7_s[5];
        end else begin
          legal_s = 1'b1;
        end
      end
      LOAD: begin
        ctrl_s.mem_read = 1'b1;
        ctrl_s.reg_wen  = 1'b1;
        ctrl_s.alu_src  = 1'b1;
        ctrl_s.opsel    = funct3_s;
        legal_s = (funct3_s != 3'd3) && (funct3_s != 3'd6) && (funct3_s != 3'd7);
      end
      STORE: begin
        ctrl_s.mem_write = 1'b1;
        ctrl_s.alu_src   = 1'b1;
        ctrl_s.opsel     = funct3_s;
        legal_s = (funct3_s < 3'd3);
      end
      BRANCH: begin
        ctrl_s.branch = 1'b1;
        ctrl_s.opsel  = funct3_s;
        legal_s = (funct3_s != 3'd2) && (funct3_s != 3'd3);
      end
      JAL: begin
        ctrl_s.jal     = 1'b1;
        ctrl_s.reg_wen = 1'b1;
      end
      JALR: begin
        ctrl_s.jalr    = 1'b1;
        ctrl_s.reg_wen = 1'b1;
        ctrl_s.alu_src = 1'b1;
        ctrl_s.opsel   = funct3_s;
        legal_s = (funct3_s == 3'd0);
      end
      LUI: begin
        ctrl_s.lui     = 1'b1;
        ctrl_s.reg_wen = 1'b1;
        ctrl_s.alu_src = 1'b1;
      end
      AUIPC: begin
        ctrl_s.auipc   = 1'b1;
        ctrl_s.reg_wen = 1'b1;
        ctrl_s.alu_src = 1'b1;
      end
      SYSTEM: begin
        // ecall passes through as a no-op; ebreak and any CSR form halt
        if (i_inst == EBREAK) begin
          legal_s = 1'b0;
        end else if (i_inst == ECALL) begin
          legal_s = 1'b1;
        end else begin
          legal_s = 1'b0;
        end
      end
      default: legal_s = 1'b0;
    endcase
  end

  assign halt_req_s = ~legal_s | ~fmt_vld_s;

  assign hold_s = i_vld & i_ex_mem_read & (i_ex_rd != 5'd0) &
                  ((uses_rs1(opcode_s) & (rs1_s == i_ex_rd)) |
                   (uses_rs2(opcode_s) & (rs2_s == i_ex_rd))) &
                  (state_r == RUN) & ~i_flush;
  assign o_hold = hold_s;

  // Issue decision and next FSM state: flush > halt > hold > decode
  always_comb begin
    state_nxt_s = state_r;
    issue_s     = 1'b0;
    halt_take_s = 1'b0;
    if (i_flush) begin
      state_nxt_s = state_r;
    end else if (state_r == HALT) begin
      state_nxt_s = HALT;
    end else if (hold_s || !i_vld) begin
      state_nxt_s = RUN;
    end else begin
      issue_s = 1'b1;
      if (halt_req_s) begin
        halt_take_s = 1'b1;
        state_nxt_s = HALT;
      end else begin
        state_nxt_s = RUN;
      end
    end
  end

  // FSM state and ID/EX pipeline register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r  <= RUN;
      halt_r   <= 1'b0;
      vld_r    <= 1'b0;
      ctrl_r   <= CTRL_NONE;
      rd_r     <= 5'd0;
      inst_r   <= NOP_INST;
      pc_r     <= 32'h0000_0000;
      nxt_pc_r <= 32'h0000_0000;
      rs1_r    <= 32'h0000_0000;
      rs2_r    <= 32'h0000_0000;
      imm_r    <= 32'h0000_0000;
    end else begin
      state_r  <= state_nxt_s;
      halt_r   <= (state_nxt_s == HALT);
      pc_r     <= i_pc;
      nxt_pc_r <= i_nxt_pc;
      rs1_r    <= rs1_val_s;
      rs2_r    <= rs2_val_s;
      imm_r    <= imm_s;
      if (issue_s) begin
        vld_r  <= 1'b1;
        inst_r <= i_inst;
        ctrl_r <= halt_take_s ? CTRL_NONE : ctrl_s;
        rd_r   <= (halt_take_s || !ctrl_s.reg_wen) ? 5'd0 : rd_s;
      end else begin
        vld_r  <= 1'b0;
        inst_r <= NOP_INST;
        ctrl_r <= CTRL_NONE;
        rd_r   <= 5'd0;
      end
    end
  end

  assign o_halt      = halt_r;
  assign o_vld       = vld_r;
  assign o_inst      = inst_r;
  assign o_rd        = rd_r;
  assign o_pc        = pc_r;
  assign o_nxt_pc    = nxt_pc_r;
  assign o_rs1_rdata = rs1_r;
  assign o_rs2_rdata = rs2_r;
  assign o_imm       = imm_r;
  assign o_opsel     = ctrl_r.opsel;
  assign o_sub_sra   = ctrl_r.sub_sra;
  assign o_alu_src   = ctrl_r.alu_src;
  assign o_branch    = ctrl_r.branch;
  assign o_jal       = ctrl_r.jal;
  assign o_jalr      = ctrl_r.jalr;
  assign o_mem_read  = ctrl_r.mem_read;
  assign o_mem_write = ctrl_r.mem_write;
  assign o_reg_wen   = ctrl_r.reg_wen;
  assign o_lui       = ctrl_r.lui;
  assign o_auipc     = ctrl_r.auipc;

endmodule

// File: tb/tb_dec.sv
// Randomized bench for the decode stage against an instruction-level model.
module tb_dec;

  logic        i_clk = 1'b0;
  logic        i_rst, i_vld, i_flush, i_ex_mem_read, i_wb_wen;
  logic [31:0] i_inst, i_pc, i_nxt_pc, i_rs1_rdata, i_rs2_rdata, i_wb_data;
  logic [4:0]  i_ex_rd, i_wb_rd;
  logic [4:0]  o_rs1_raddr, o_rs2_raddr, o_rd;
  logic        o_hold, o_halt, o_sub_sra, o_alu_src, o_branch, o_jal, o_jalr;
  logic        o_mem_read, o_mem_write, o_reg_wen, o_lui, o_auipc, o_vld;
  logic [31:0] o_pc, o_nxt_pc, o_rs1_rdata, o_rs2_rdata, o_imm, o_inst;
  logic [2:0]  o_opsel;

  always #5 i_clk = ~i_clk;

  dec dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_inst(i_inst), .i_pc(i_pc), .i_nxt_pc(i_nxt_pc),
    .i_vld(i_vld), .i_flush(i_flush), .o_rs1_raddr(o_rs1_raddr), .o_rs2_raddr(o_rs2_raddr),
    .i_rs1_rdata(i_rs1_rdata), .i_rs2_rdata(i_rs2_rdata), .i_ex_rd(i_ex_rd),
    .i_ex_mem_read(i_ex_mem_read), .i_wb_rd(i_wb_rd), .i_wb_wen(i_wb_wen), .i_wb_data(i_wb_data),
    .o_hold(o_hold), .o_halt(o_halt), .o_pc(o_pc), .o_nxt_pc(o_nxt_pc),
    .o_rs1_rdata(o_rs1_rdata), .o_rs2_rdata(o_rs2_rdata), .o_imm(o_imm), .o_rd(o_rd),
    .o_opsel(o_opsel), .o_sub_sra(o_sub_sra), .o_alu_src(o_alu_src), .o_branch(o_branch),
    .o_jal(o_jal), .o_jalr(o_jalr), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
    .o_reg_wen(o_reg_wen), .o_lui(o_lui), .o_auipc(o_auipc), .o_inst(o_inst), .o_vld(o_vld)
  );

  typedef struct packed {
    logic        vld, halt, data_chk;
    logic [31:0] pc, npc, a, b, imm, inst;
    logic [4:0]  rd;
    logic [12:0] ctrl; // br,jal,jalr,mr,mw,rw,lui,auipc,alu_src,sub_sra,opsel[2:0]
  } exp_t;

  localparam logic [31:0] NOP = 32'h0000_0033;

  int          total = 0;
  int          bad = 0;
  bit          chk_en = 1'b0;
  bit          pend_ok = 1'b0;
  bit          m_halt = 1'b0;
  logic        exp_hold = 1'b0;
  exp_t        cur, pend;
  logic [31:0] regs [32];
  logic [31:0] pc_q = 32'h0000_1000;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sx(input logic [31:0] w, input int sh);
    return 32'($signed(w) >>> sh);
  endfunction

  // Instruction-level meaning: immediate, control set, and whether it stops the core
  function automatic void model_dec(input logic [31:0] w, output exp_t e, output bit halts);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic br, jl, jr, mr, mw, rw, lu, au, src, sub;
    logic [2:0] sel;
    op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    e = '0;
    {br, jl, jr, mr, mw, rw, lu, au, src, sub} = 10'b0;
    sel = f3;
    halts = 1'b0;
    case (op)
      7'h33: begin rw = 1; sub = f7[5];
        halts = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))); end
      7'h13: begin rw = 1; src = 1; e.imm = sx(w, 20);
        sub = (f3 == 3'd5) ? f7[5] : 1'b0;
        halts = (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20); end
      7'h03: begin rw = 1; src = 1; mr = 1; e.imm = sx(w, 20);
        halts = (f3 == 3'd3 || f3 >= 3'd6); end
      7'h23: begin mw = 1; src = 1; e.imm = (sx(w, 25) << 5) | 32'(w[11:7]);
        halts = (f3 > 3'd2); end
      7'h63: begin br = 1;
        e.imm = (sx(w, 31) << 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
        halts = (f3 == 3'd2 || f3 == 3'd3); end
      7'h6F: begin jl = 1; rw = 1; sel = 3'd0;
        e.imm = (sx(w, 31) << 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1); end
      7'h67: begin jr = 1; rw = 1; src = 1; e.imm = sx(w, 20); halts = (f3 != 3'd0); end
      7'h37: begin lu = 1; rw = 1; src = 1; sel = 3'd0; e.imm = w & 32'hFFFF_F000; end
      7'h17: begin au = 1; rw = 1; src = 1; sel = 3'd0; e.imm = w & 32'hFFFF_F000; end
      7'h73: begin sel = 3'd0; e.imm = sx(w, 20); halts = (w != 32'h0000_0073); end
      default: begin sel = 3'd0; halts = 1'b1; end
    endcase
    if (halts) e.ctrl = 13'h0;
    else e.ctrl = {br, jl, jr, mr, mw, rw, lu, au, src, sub, sel};
    e.rd = (rw && !halts) ? w[11:7] : 5'd0;
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] r, input logic wbw,
                                          input logic [4:0] wbrd, input logic [31:0] wbd);
    if (r == 5'd0) return 32'h0;
    if (wbw && wbrd == r) return wbd;
    return regs[r];
  endfunction

  task automatic step(input logic [31:0] w, input logic v, input logic fl, input logic rs,
                      input logic [4:0] exrd, input logic exmr,
                      input logic [4:0] wbrd, input logic wbw, input logic [31:0] wbd);
    exp_t e, n;
    bit   halts, u1, u2, h;
    @(posedge i_clk); #1;
    if (pend_ok) begin cur = pend; chk_en = 1'b1; end
    pc_q = pc_q + 32'd4;
    i_inst = w; i_vld = v; i_flush = fl; i_rst = rs;
    i_ex_rd = exrd; i_ex_mem_read = exmr; i_wb_rd = wbrd; i_wb_wen = wbw; i_wb_data = wbd;
    i_pc = pc_q; i_nxt_pc = pc_q + 32'd4;
    i_rs1_rdata = regs[w[19:15]]; i_rs2_rdata = regs[w[24:20]];
    #1;
    model_dec(w, e, halts);
    u1 = (w[6:0] inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67});
    u2 = (w[6:0] inside {7'h33, 7'h23, 7'h63});
    h = v && exmr && exrd != 5'd0 && ((u1 && w[19:15] == exrd) || (u2 && w[24:20] == exrd))
        && !m_halt && !fl;
    exp_hold = h;
    n = '0; n.inst = NOP;
    if (rs) begin
      n.data_chk = 1'b1;
      m_halt = 1'b0;
    end else if (!(fl || m_halt || h || !v)) begin
      n = e; n.vld = 1'b1; n.inst = w; n.data_chk = 1'b1;
      n.pc = pc_q; n.npc = pc_q + 32'd4;
      n.a = operand(w[19:15], wbw, wbrd, wbd);
      n.b = operand(w[24:20], wbw, wbrd, wbd);
      if (halts) m_halt = 1'b1;
    end
    n.halt = m_halt;
    pend = n;
    pend_ok = 1'b1;
  endtask

  task automatic idle();
    step(NOP, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0);
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge i_clk) begin
    if (chk_en) begin
      chk("hold", 32'(o_hold), 32'(exp_hold));
      chk("rs1_raddr", 32'(o_rs1_raddr), 32'(i_inst[19:15]));
      chk("rs2_raddr", 32'(o_rs2_raddr), 32'(i_inst[24:20]));
      chk("vld", 32'(o_vld), 32'(cur.vld));
      chk("halt", 32'(o_halt), 32'(cur.halt));
      chk("ctrl", 32'({o_branch, o_jal, o_jalr, o_mem_read, o_mem_write, o_reg_wen, o_lui,
                       o_auipc, o_alu_src, o_sub_sra, o_opsel}), 32'(cur.ctrl));
      chk("rd", 32'(o_rd), 32'(cur.rd));
      chk("inst", o_inst, cur.inst);
      if (cur.data_chk) begin
        chk("pc", o_pc, cur.pc);
        chk("nxt_pc", o_nxt_pc, cur.npc);
        chk("rs1_rdata", o_rs1_rdata, cur.a);
        chk("rs2_rdata", o_rs2_rdata, cur.b);
        chk("imm", o_imm, cur.imm);
      end
    end
  end

  logic [6:0] ops [12] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17,
                          7'h73, 7'h0F, 7'h7F};

  initial begin
    logic [31:0] w;
    int          r;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    i_rst = 1'b1; i_vld = 1'b0; i_flush = 1'b0; i_inst = NOP; i_pc = 32'h0; i_nxt_pc = 32'h0;
    i_ex_rd = 5'd0; i_ex_mem_read = 1'b0; i_wb_rd = 5'd0; i_wb_wen = 1'b0; i_wb_data = 32'h0;
    i_rs1_rdata = 32'h0; i_rs2_rdata = 32'h0;

    step(NOP, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0);
    step(NOP, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0);
    chk("rst_vld", 32'(o_vld), 32'h0);
    chk("rst_inst", o_inst, 32'h0000_0033);
    chk("rst_halt", 32'(o_halt), 32'h0);

    // addi x1,x0,-5
    step(32'hFFB0_0093, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0);
    idle();
    chk("addi_imm", o_imm, 32'hFFFF_FFFB);
    chk("addi_rd", 32'(o_rd), 32'd1);
    chk("addi_src_wen", 32'({o_alu_src, o_reg_wen}), 32'h3);

    // beq x1,x2,-8 with both operands 7
    regs[1] = 32'd7; regs[2] = 32'd7;
    step(32'hFE20_8CE3, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0);
    idle();
    chk("beq_imm", o_imm, 32'hFFFF_FFF8);
    chk("beq_br_opsel", 32'({o_branch, o_opsel}), 32'h8);
    chk("beq_ops", {o_rs1_rdata[15:0], o_rs2_rdata[15:0]}, 32'h0007_0007);

    // load-use: lw x3 in EX, add x4,x3,x5 in ID
    step(32'h0051_8233, 1'b1, 1'b0, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 32'h0);
    chk("lu_hold", 32'(o_hold), 32'h1);
    step(32'h0051_8233, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0);
    chk("lu_hold_clr", 32'(o_hold), 32'h0);
    chk("lu_bubble", 32'(o_vld), 32'h0);
    idle();
    chk("lu_issue", {27'h0, o_rd}, 32'd4);

    // load into x0 never stalls
    step(32'h0000_0233, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 32'h0);
    chk("x0_nohold", 32'(o_hold), 32'h0);

    // WB bypass: add x7,x6,x0 with stale x6
    regs[6] = 32'h0;
    step(32'h0003_03B3, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 32'hDEAD_BEEF);
    idle();
    chk("bypass", o_rs1_rdata, 32'hDEAD_BEEF);

    // ebreak killed by flush, then real ebreak, then reset
    step(32'h0010_0073, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0);
    idle();
    chk("ebrk_flush", 32'(o_halt), 32'h0);
    step(32'h0010_0073, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0);
    step(32'hFFB0_0093, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0);
    chk("ebrk_halt", 32'(o_halt), 32'h1);
    idle();
    chk("halt_bubble", 32'(o_vld), 32'h0);
    step(NOP, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0);
    idle();
    chk("rst_unhalt", 32'(o_halt), 32'h0);

    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 99);
      if (r < 2) w = 32'h0010_0073;
      else if (r < 4) w = 32'h0000_0073;
      else begin
        w = $urandom;
        w[6:0] = ops[$urandom_range(0, 11)];
        if (w[6:0] == 7'h33 || w[6:0] == 7'h13) begin
          if ($urandom_range(0, 7) != 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        end
      end
      if ($urandom_range(0, 1) != 0) w[19:15] = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 1) != 0) w[24:20] = 5'($urandom_range(0, 7));
      step(w, $urandom_range(0, 99) < 85, $urandom_range(0, 9) == 0,
           (m_halt && $urandom_range(0, 1) != 0) || $urandom_range(0, 99) == 0,
           5'($urandom_range(0, 7)), $urandom_range(0, 9) < 3,
           5'($urandom_range(0, 7)), $urandom_range(0, 9) < 4, $urandom);
    end
    idle();
    @(posedge i_clk); #1;
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
